// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and destination scoreboard for the vector/scalar register file.
// Define WB_RR_ARB_EN for round-robin tie-break; otherwise MEM has fixed priority.
module regfile_wb_arbiter #(
   parameter int NLANES = 16,
   parameter int DW     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic                 alu_vs,
   input  logic [3:0]           alu_rd,
   input  logic [NLANES*DW-1:0] alu_data,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic                 mem_vs,
   input  logic [3:0]           mem_rd,
   input  logic [NLANES*DW-1:0] mem_data,
   input  logic                 rsv_valid,
   input  logic                 rsv_vs,
   input  logic [3:0]           rsv_rd,
   input  logic                 chk_vs,
   input  logic [3:0]           chk_ra1,
   input  logic [3:0]           chk_ra2,
   output logic                 hazard,
   output logic                 we3,
   output logic [3:0]           ra3,
   output logic [NLANES*DW-1:0] wd3,
   output logic                 selec_v_s_w,
   output logic                 err
);
   localparam int W = NLANES * DW;

   logic [15:0]  sbusy, vbusy;
   logic [15:0]  clr_oh, set_oh, sbusy_nxt, vbusy_nxt;
   logic         gnt_alu, gnt_mem, gnt, g_vs, g_busy, g_r15;
   logic [3:0]   g_rd;
   logic [W-1:0] g_data;
   logic         rsv_busy, rsv_clr, err_nxt, hz1, hz2;

`ifdef WB_RR_ARB_EN
   logic last_alu;

   always_comb begin
      gnt_alu = rst & alu_valid & (~mem_valid | ~last_alu);
      gnt_mem = rst & mem_valid & (~alu_valid | last_alu);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     last_alu <= 1'b0;
      else if (gnt) last_alu <= gnt_alu;
   end
`else
   always_comb begin
      gnt_alu = rst & alu_valid & ~mem_valid;
      gnt_mem = rst & mem_valid;
   end
`endif

   assign alu_ready = gnt_alu;
   assign mem_ready = gnt_mem;

   always_comb begin
      gnt    = gnt_alu | gnt_mem;
      g_vs   = gnt_alu ? alu_vs   : mem_vs;
      g_rd   = gnt_alu ? alu_rd   : mem_rd;
      g_data = gnt_alu ? alu_data : mem_data;
      g_busy = g_vs ? vbusy[g_rd] : sbusy[g_rd];
      g_r15  = ~g_vs & (g_rd == 4'd15);

      // r15 is the PC: scalar index 15 never reports a hazard
      hz1    = (chk_vs ? vbusy[chk_ra1] : sbusy[chk_ra1]) & ~(~chk_vs & (chk_ra1 == 4'd15));
      hz2    = (chk_vs ? vbusy[chk_ra2] : sbusy[chk_ra2]) & ~(~chk_vs & (chk_ra2 == 4'd15));
      hazard = hz1 | hz2;

      // The write in the we3 cycle retires at this edge; a reservation landing on it is legal
      clr_oh    = we3       ? (16'd1 << ra3)    : 16'd0;
      set_oh    = rsv_valid ? (16'd1 << rsv_rd) : 16'd0;
      sbusy_nxt = (sbusy & ~(selec_v_s_w ? 16'd0 : clr_oh)) | (rsv_vs ? 16'd0 : set_oh);
      vbusy_nxt = (vbusy & ~(selec_v_s_w ? clr_oh : 16'd0)) | (rsv_vs ? set_oh : 16'd0);

      rsv_busy = rsv_vs ? vbusy[rsv_rd] : sbusy[rsv_rd];
      rsv_clr  = we3 & (selec_v_s_w == rsv_vs) & (ra3 == rsv_rd);
      err_nxt  = (rsv_valid & rsv_busy & ~rsv_clr) | (gnt & (g_r15 | ~g_busy));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sbusy       <= '0;
         vbusy       <= '0;
         we3         <= 1'b0;
         ra3         <= '0;
         wd3         <= '0;
         selec_v_s_w <= 1'b0;
         err         <= 1'b0;
      end else begin
         sbusy <= sbusy_nxt;
         vbusy <= vbusy_nxt;
         err   <= err_nxt;
         we3   <= gnt & ~g_r15;
         if (gnt) begin
            ra3         <= g_rd;
            wd3         <= g_data;
            selec_v_s_w <= g_vs;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;
   localparam int NL = 16;
   localparam int DW = 32;
   localparam int W  = NL * DW;

   logic clk = 1'b0;
   logic rst;
   logic alu_valid, alu_ready, alu_vs, mem_valid, mem_ready, mem_vs;
   logic [3:0] alu_rd, mem_rd, rsv_rd, chk_ra1, chk_ra2, ra3;
   logic [W-1:0] alu_data, mem_data, wd3;
   logic rsv_valid, rsv_vs, chk_vs, hazard, we3, selec_v_s_w, err;

   int errors = 0;
   int checks = 0;

   // model state
   bit [15:0] m_sb, m_vb;
   bit        m_last_alu, m_we, m_sel, m_err, m_g_alu, m_g_mem;
   bit [3:0]  m_ra;
   bit [W-1:0] m_wd;

   regfile_wb_arbiter #(.NLANES(NL), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_vs(alu_vs), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_vs(mem_vs), .mem_rd(mem_rd), .mem_data(mem_data),
      .rsv_valid(rsv_valid), .rsv_vs(rsv_vs), .rsv_rd(rsv_rd),
      .chk_vs(chk_vs), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .hazard(hazard),
      .we3(we3), .ra3(ra3), .wd3(wd3), .selec_v_s_w(selec_v_s_w), .err(err)
   );

   always #5 clk = ~clk;

   function automatic bit m_busy(bit vs, bit [3:0] idx);
      return vs ? m_vb[idx] : m_sb[idx];
   endfunction

   function automatic bit m_hazard();
      bit h1, h2;
      if (rst !== 1'b1) return 1'b0;
      h1 = m_busy(chk_vs, chk_ra1) && !(!chk_vs && chk_ra1 == 4'd15);
      h2 = m_busy(chk_vs, chk_ra2) && !(!chk_vs && chk_ra2 == 4'd15);
      return h1 || h2;
   endfunction

   // 0 = no grant, 1 = ALU, 2 = MEM
   function automatic int m_pick();
      if (rst !== 1'b1) return 0;
      if (alu_valid && mem_valid) begin
`ifdef WB_RR_ARB_EN
         return m_last_alu ? 2 : 1;
`else
         return 2;
`endif
      end
      if (alu_valid) return 1;
      if (mem_valid) return 2;
      return 0;
   endfunction

   task automatic m_reset();
      m_sb = '0; m_vb = '0; m_last_alu = 0; m_we = 0; m_sel = 0; m_err = 0;
      m_ra = '0; m_wd = '0; m_g_alu = 0; m_g_mem = 0;
   endtask

   task automatic idle();
      alu_valid = 0; alu_vs = 0; alu_rd = '0; alu_data = '0;
      mem_valid = 0; mem_vs = 0; mem_rd = '0; mem_data = '0;
      rsv_valid = 0; rsv_vs = 0; rsv_rd = '0;
      chk_vs = 0; chk_ra1 = '0; chk_ra2 = '0;
   endtask

   // Advance one clock: evaluate the rules on the pre-edge inputs, then commit at the edge.
   task automatic tick();
      int g;
      bit gvs, nerr;
      bit [3:0] grd;
      bit [W-1:0] gd;
      bit [15:0] sb, vb;
      g   = m_pick();
      gvs = (g == 1) ? alu_vs : mem_vs;
      grd = (g == 1) ? alu_rd : mem_rd;
      gd  = (g == 1) ? alu_data : mem_data;
      nerr = 0;
      if (rsv_valid && m_busy(rsv_vs, rsv_rd) && !(m_we && m_sel == rsv_vs && m_ra == rsv_rd)) nerr = 1;
      if (g != 0 && ((!gvs && grd == 4'd15) || !m_busy(gvs, grd))) nerr = 1;
      sb = m_sb; vb = m_vb;
      if (m_we) begin
         if (m_sel) vb[m_ra] = 0;
         else       sb[m_ra] = 0;
      end
      if (rsv_valid) begin
         if (rsv_vs) vb[rsv_rd] = 1;
         else        sb[rsv_rd] = 1;
      end
      @(posedge clk);
      if (rst === 1'b1) begin
         m_sb = sb; m_vb = vb; m_err = nerr;
         m_g_alu = (g == 1); m_g_mem = (g == 2);
         m_we = (g != 0) && !(!gvs && grd == 4'd15);
         if (g != 0) begin
            m_ra = grd; m_sel = gvs; m_wd = gd; m_last_alu = (g == 1);
         end
      end else m_reset();
      #1;
   endtask

   task automatic test_reset();
      rst = 0; idle();
      repeat (2) @(posedge clk);
      #1;
      alu_valid = 1; mem_valid = 1; chk_ra1 = 4'd3;
      #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b want 0", we3); end
      checks++; if (ra3 !== 4'd0) begin errors++; $display("FAIL reset_ra3: got %0d want 0", ra3); end
      checks++; if (wd3 !== '0) begin errors++; $display("FAIL reset_wd3: got %0h want 0", wd3); end
      checks++; if (selec_v_s_w !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", selec_v_s_w); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", alu_ready, mem_ready); end
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", hazard); end
      idle();
   endtask

   task automatic test_basic_write();
      rst = 1;
      alu_valid = 1; alu_vs = 1; alu_rd = 4'd3;
      for (int k = 0; k < NL; k++) alu_data[k*DW +: DW] = 32'(k);
      #1;
      checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b%b want 10", alu_ready, mem_ready); end
      tick();
      alu_valid = 0;
      checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL basic_we3: got %b want 1", we3); end
      checks++; if (ra3 !== 4'd3) begin errors++; $display("FAIL basic_ra3: got %0d want 3", ra3); end
      checks++; if (selec_v_s_w !== 1'b1) begin errors++; $display("FAIL basic_sel: got %b want 1", selec_v_s_w); end
      checks++; if (wd3[5*DW +: DW] !== 32'd5) begin errors++; $display("FAIL basic_lane5: got %0d want 5", wd3[5*DW +: DW]); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL basic_err: got %b want %b", err, m_err); end
      #1;
      tick();
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL basic_we3_drop: got %b want 0", we3); end
   endtask

   task automatic test_hazard();
      rsv_valid = 1; rsv_vs = 0; rsv_rd = 4'd15;
      #1; tick();
      rsv_valid = 0; chk_vs = 0; chk_ra1 = 4'd15; chk_ra2 = 4'd15;
      #1;
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_r15: got %b want 0", hazard); end
      rsv_valid = 1; rsv_vs = 0; rsv_rd = 4'd4;
      #1; tick();
      rsv_valid = 0; chk_ra1 = 4'd4; chk_ra2 = 4'd0;
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hazard_set: got %b want 1", hazard); end
      mem_valid = 1; mem_vs = 0; mem_rd = 4'd4; mem_data = {16{$urandom()}};
      #1;
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL hazard_mem_ready: got %b want 1", mem_ready); end
      tick();
      mem_valid = 0;
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hazard_hold: got %b want 1", hazard); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL hazard_err: got %b want 0", err); end
      tick();
      checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_clear: got %b want 0", hazard); end
   endtask

   task automatic test_tiebreak();
      bit exp_alu;
      alu_valid = 1; alu_vs = 0; alu_rd = 4'd5; alu_data = {16{32'hA1A1_0005}};
      mem_valid = 1; mem_vs = 0; mem_rd = 4'd6; mem_data = {16{32'hB2B2_0006}};
      for (int i = 0; i < 4; i++) begin
         #1;
`ifdef WB_RR_ARB_EN
         exp_alu = (i % 2 == 0);
`else
         exp_alu = 1'b0;
`endif
         checks++; if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin errors++; $display("FAIL tie_grant%0d: got %b%b want %b%b", i, alu_ready, mem_ready, exp_alu, !exp_alu); end
         tick();
         checks++; if (we3 !== 1'b1 || ra3 !== (exp_alu ? 4'd5 : 4'd6)) begin errors++; $display("FAIL tie_write%0d: got we3=%b ra3=%0d want 1/%0d", i, we3, ra3, exp_alu ? 5 : 6); end
      end
      idle();
   endtask

   task automatic test_collision();
      rsv_valid = 1; rsv_vs = 1; rsv_rd = 4'd2;
      #1; tick();
      rsv_valid = 0; alu_valid = 1; alu_vs = 1; alu_rd = 4'd2; alu_data = {16{$urandom()}};
      #1; tick();
      alu_valid = 0;
      checks++; if (we3 !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL coll_write: got we3=%b err=%b want 1/0", we3, err); end
      rsv_valid = 1; rsv_vs = 1; rsv_rd = 4'd2; chk_vs = 1; chk_ra1 = 4'd2; chk_ra2 = 4'd2;
      #1; tick();
      rsv_valid = 0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL coll_err: got %b want 0", err); end
      #1;
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b want 1", hazard); end
      idle();
   endtask

   task automatic test_r15();
      alu_valid = 1; alu_vs = 0; alu_rd = 4'd15; alu_data = {16{$urandom()}};
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL r15_ready: got %b want 1", alu_ready); end
      tick();
      alu_valid = 0;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL r15_we3: got %b want 0", we3); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL r15_err: got %b want 1", err); end
      #1; tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL r15_err_once: got %b want 0", err); end
   endtask

   task automatic test_random();
      bit alu_hold, mem_hold;
      int g;
      alu_hold = 0; mem_hold = 0;
      for (int c = 0; c < 400; c++) begin
         if (!alu_hold) begin
            alu_valid = ($urandom_range(0, 2) != 0); alu_vs = $urandom_range(0, 1);
            alu_rd = 4'($urandom_range(0, 15));
            for (int k = 0; k < NL; k++) alu_data[k*DW +: DW] = $urandom();
         end
         if (!mem_hold) begin
            mem_valid = ($urandom_range(0, 2) != 0); mem_vs = $urandom_range(0, 1);
            mem_rd = 4'($urandom_range(0, 15));
            for (int k = 0; k < NL; k++) mem_data[k*DW +: DW] = $urandom();
         end
         rsv_valid = ($urandom_range(0, 3) == 0); rsv_vs = $urandom_range(0, 1);
         rsv_rd = 4'($urandom_range(0, 15));
         chk_vs = $urandom_range(0, 1); chk_ra1 = 4'($urandom_range(0, 15)); chk_ra2 = 4'($urandom_range(0, 15));
         #1;
         g = m_pick();
         checks++; if (alu_ready !== (g == 1) || mem_ready !== (g == 2)) begin errors++; $display("FAIL rnd_grant c=%0d: got %b%b want %b%b", c, alu_ready, mem_ready, g == 1, g == 2); end
         checks++; if (hazard !== m_hazard()) begin errors++; $display("FAIL rnd_hazard c=%0d: got %b want %b", c, hazard, m_hazard()); end
         tick();
         alu_hold = alu_valid && !m_g_alu;
         mem_hold = mem_valid && !m_g_mem;
         checks++; if (we3 !== m_we || err !== m_err) begin errors++; $display("FAIL rnd_wb c=%0d: got we3=%b err=%b want %b/%b", c, we3, err, m_we, m_err); end
         if (m_we) begin
            checks++; if (ra3 !== m_ra || selec_v_s_w !== m_sel || wd3 !== m_wd) begin errors++; $display("FAIL rnd_payload c=%0d: got ra3=%0d sel=%b wd3=%0h want %0d/%b/%0h", c, ra3, selec_v_s_w, wd3, m_ra, m_sel, m_wd); end
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      rsv_valid = 1; rsv_vs = 1; rsv_rd = 4'd9;
      alu_valid = 1; alu_vs = 0; alu_rd = 4'd7; alu_data = {16{32'hC0DE_0007}};
      #1; tick();
      idle();
      checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL rmid_we3_before: got %b want 1", we3); end
      #2; rst = 0;
      #1;
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL rmid_we3_async: got %b want 0", we3); end
      m_reset();
      repeat (2) @(posedge clk);
      #1; rst = 1;
      for (int i = 0; i < 32; i++) begin
         chk_vs = i[4]; chk_ra1 = i[3:0]; chk_ra2 = i[3:0];
         #1;
         checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rmid_hazard vs=%0d idx=%0d: got %b want 0", i[4], i[3:0], hazard); end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_basic_write();
      test_hazard();
      test_tiebreak();
      test_collision();
      test_r15();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back controller for the 16-lane vector / 15-entry scalar register file. It arbitrates between the ALU and memory-load result streams for the file's single write port (`we3`/`ra3`/`wd3`/`selec_v_s_w`). It also keeps a destination scoreboard that the issue stage queries for read-after-write hazards. It sits between the execute/memory stages and the register file, and its write-port outputs are registered so that the file's negedge write lands mid-cycle.

## Interface
- `NLANES`, default 16: vector lanes per register.
- `DW`, default 32: lane width in bits.
- `clk` input, 1 bit: clock. All state updates on posedge.
- `rst` input, 1 bit: asynchronous reset, active-low (asserted at 0).
- `alu_valid`, `mem_valid` input, 1 bit each: write-back request.
- `alu_ready`, `mem_ready` output, 1 bit each: grant. Combinational; the transfer happens on valid & ready at posedge.
- `alu_vs`, `mem_vs` input, 1 bit each: 1 = vector destination, 0 = scalar.
- `alu_rd`, `mem_rd` input, 4 bits each: destination index.
- `alu_data`, `mem_data` input, NLANES×DW each: result. Scalar results use lane 0.
- `rsv_valid` input, 1 bit: issue stage reserves a destination.
- `rsv_vs` input, 1 bit: class of the register being reserved.
- `rsv_rd` input, 4 bits: index of the register being reserved.
- `chk_vs` input, 1 bit: class of the registers being checked.
- `chk_ra1`, `chk_ra2` input, 4 bits each: source indices to check.
- `hazard` output, 1 bit: combinational. Set when either checked source is busy.
- `we3` output, 1 bit: register-file write enable. Registered.
- `ra3` output, 4 bits: write index. Registered.
- `wd3` output, NLANES×DW: write data. Registered.
- `selec_v_s_w` output, 1 bit: write class, 1 = vector. Registered.
- `err` output, 1 bit: one-cycle pulse on a protocol error.

## Operation
- **Scoreboard.** Two 16-bit busy vectors, `sbusy` and `vbusy`.
  - `rsv_valid` sets the busy bit for (`rsv_vs`, `rsv_rd`).
  - A completed write clears it.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Hazard check.** `hazard` = busy[`chk_vs`][`chk_ra1`] | busy[`chk_vs`][`chk_ra2`].
  - When `chk_vs`=0 and the index is 15 (r15/PC), that source never reports busy.
- **Arbitration.** At most one grant per cycle, with no idle cycle between back-to-back grants.
  - Only ALU valid: the ALU is granted.
  - Only MEM valid: MEM is granted.
  - Both valid: the requester not granted last is granted. The `last` pointer resets to MEM, so the ALU wins the first tie.
  - A request that is not granted must hold valid and its payload stable.
- **Write stage.** On a grant edge N, `we3`, `ra3`, `wd3` and `selec_v_s_w` are loaded from the granted payload. `we3` is high for cycle N+1 only, unless another grant occurs at edge N+1.
- **Scalar rd=15.** A scalar write to rd=15 is accepted (ready is given) but does not drive `we3`, since r15 is not writable. It pulses `err` and clears nothing.
- **Protocol errors.** `err` also pulses in these cases:
  - `rsv_valid` targets a register that is already busy. The bit stays set.
  - A write-back is granted for a register that is not busy. The write still proceeds.
- **Reset.** While `rst`=0, all outputs and state are forced to their reset values regardless of clock:
  - `we3`=0, `ra3`=0, `wd3`=0, `selec_v_s_w`=0, `err`=0.
  - `sbusy`=0 and `vbusy`=0.
  - `last`=MEM.
  - Consequently `alu_ready`, `mem_ready` and `hazard` are 0.
  - A write in flight when reset asserts is dropped: `we3` falls immediately.

## Timing
- Grant at posedge N → `we3` high in cycle N+1 → the file writes at the negedge inside N+1.
- The busy bit clears at posedge N+2, on the edge ending the `we3` cycle. Its `hazard` contribution therefore drops in cycle N+2.
- Reservation at posedge N → `hazard` visible in cycle N+1.
- Sustained throughput is 1 write/cycle.
- With both requesters continuously valid, each is granted every other cycle.

## Configuration
- `WB_RR_ARB_EN` defined: round-robin tie-break as described above.
- `WB_RR_ARB_EN` undefined: fixed priority, MEM always wins ties. The `last` pointer is not implemented; the ALU can starve while MEM is continuously valid.

## Test plan
- **Reset values.** Reset low → all outputs 0. Reset high with ALU valid, vs=1, rd=3, lane k = k → `we3`=1, `ra3`=3, `selec_v_s_w`=1, `wd3` lane 5 = 5 in the next cycle.
- **Scoreboard hazard.** Reserve scalar 4, then check `chk_vs`=0, `chk_ra1`=4 → `hazard`=1 from cycle N+1. MEM writes scalar 4 at grant edge G → `hazard` stays 1 through G+1 and drops at G+2.
- **Tie-break.** ALU and MEM both held valid for 4 cycles.
  - With `WB_RR_ARB_EN` defined: grant order ALU, MEM, ALU, MEM.
  - With `WB_RR_ARB_EN` undefined: MEM ×4, `alu_ready`=0 throughout.
- **Set/clear collision.** Reserve vector 2 in the same cycle its write completes → `vbusy`[2] remains 1 and `err`=0.
- **Scalar rd=15.** ALU scalar write to rd=15 → `alu_ready`=1, `we3` stays 0, `err` pulses once.
- **Reset mid-operation.** Assert reset while `we3`=1 → `we3` drops without a clock edge. After release, `hazard`=0 for every index.
